// File: rtl/mcu_exec_unit_if.sv
// -----------------------------------------------------------------------------
// mcu_exec_unit_if
//   Bundle between the execute/writeback sequencer and its surroundings:
//   the instruction valid/ready handshake, the register file's two async
//   read ports and its synchronous write port, plus status outputs.
//
//   Modports:
//     slave  - the execute unit's view (receives instructions, drives the
//              register file addresses/write port, status and flags)
//     master - the view of the instruction source / register file side
//
//   Signals:
//     instr_valid, instr_ready, instr          instruction handshake
//     rf_addr_r_1/2, rf_data_r_1/2             async read ports
//     rf_we, rf_addr_w, rf_data_w              synchronous write port
//     busy, illegal_op, flag_z, flag_c         status
// -----------------------------------------------------------------------------
interface mcu_exec_unit_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                      instr_valid;
  logic                      instr_ready;
  logic [4+3*ADDR_WIDTH-1:0] instr;

  logic [ADDR_WIDTH-1:0]     rf_addr_r_1;
  logic [ADDR_WIDTH-1:0]     rf_addr_r_2;
  logic [DATA_WIDTH-1:0]     rf_data_r_1;
  logic [DATA_WIDTH-1:0]     rf_data_r_2;

  logic                      rf_we;
  logic [ADDR_WIDTH-1:0]     rf_addr_w;
  logic [DATA_WIDTH-1:0]     rf_data_w;

  logic                      busy;
  logic                      illegal_op;
  logic                      flag_z;
  logic                      flag_c;

  modport slave (
    input  instr_valid, instr, rf_data_r_1, rf_data_r_2,
    output instr_ready, rf_addr_r_1, rf_addr_r_2,
           rf_we, rf_addr_w, rf_data_w,
           busy, illegal_op, flag_z, flag_c
  );

  modport master (
    output instr_valid, instr, rf_data_r_1, rf_data_r_2,
    input  instr_ready, rf_addr_r_1, rf_addr_r_2,
           rf_we, rf_addr_w, rf_data_w,
           busy, illegal_op, flag_z, flag_c
  );
endinterface

// File: rtl/mcu_exec_unit.sv
// -----------------------------------------------------------------------------
// mcu_exec_unit
//   Execute/writeback sequencer in front of the MCU register file.
//   One instruction {opcode[3:0], rd, rs1, rs2} is accepted per handshake and
//   walks IDLE -> DECODE -> EXEC -> WB -> IDLE:
//     DECODE : read addresses come from the latched rs1/rs2; operands are
//              captured from the async read data at the end of the cycle.
//     EXEC   : ALU result computed (one cycle; MUL iterates DATA_WIDTH cycles).
//     WB     : rf_we for exactly one cycle; flags update at the end of WB.
//   Because the write lands before the next DECODE, back-to-back dependent
//   instructions need no forwarding.
//
//   Ports:
//     clk    - system clock, rising edge
//     rst_n  - asynchronous active-low reset
//     bus    - mcu_exec_unit_if.slave (handshake, register file, status)
//
//   Build option:
//     MCU_EXU_MUL_EN - when defined, opcode 9 is an iterative shift-add
//                      multiplier; otherwise opcode 9 is illegal and no
//                      multiplier hardware exists.
// -----------------------------------------------------------------------------
module mcu_exec_unit #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  mcu_exec_unit_if.slave  bus
);

  localparam int IW  = 4 + 3*ADDR_WIDTH;
  localparam int SHW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int SHN = 1 << SHW;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_WB     = 2'd3;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MOV = 4'd8;
`ifdef MCU_EXU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd9;
`endif

  logic [1:0]            state_reg, state_next;
  logic [IW-1:0]         instr_reg;
  logic [DATA_WIDTH-1:0] op_a_reg, op_b_reg;
  logic [DATA_WIDTH-1:0] result_reg;
  logic                  carry_reg;
  logic                  flag_z_reg, flag_c_reg;

  // Instruction fields
  logic [3:0]            opcode;
  logic [ADDR_WIDTH-1:0] rd, rs1, rs2;

  assign opcode = instr_reg[IW-1 -: 4];
  assign rd     = instr_reg[3*ADDR_WIDTH-1 -: ADDR_WIDTH];
  assign rs1    = instr_reg[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
  assign rs2    = instr_reg[ADDR_WIDTH-1:0];

  // ---------------------------------------------------------------------------
  // Opcode classification
  // ---------------------------------------------------------------------------
  logic op_writes;   // result is written back and z updated
  logic op_sets_c;   // carry flag is updated
  logic op_illegal;

  always_comb begin
    op_writes  = 1'b0;
    op_sets_c  = 1'b0;
    op_illegal = 1'b0;
    case (opcode)
      OP_NOP: ;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
        op_writes = 1'b1;
        op_sets_c = 1'b1;
      end
      OP_MOV: op_writes = 1'b1;
`ifdef MCU_EXU_MUL_EN
      OP_MUL: begin
        op_writes = 1'b1;
        op_sets_c = 1'b1;
      end
`endif
      default: op_illegal = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shifter carry tables: entry gi is the last bit shifted out for a shift
  // distance of gi. Distance 0 and distances >= DATA_WIDTH give carry 0.
  // ---------------------------------------------------------------------------
  logic [SHN-1:0] shl_c, shr_c;
  logic [SHW-1:0] sh_idx;
  logic           sh_big;

  assign sh_idx = op_b_reg[SHW-1:0];
  assign sh_big = (32'(op_b_reg) >= 32'(DATA_WIDTH));

  genvar gi;
  generate
    for (gi = 0; gi < SHN; gi++) begin : g_shift_c
      if (gi >= 1 && gi < DATA_WIDTH) begin : g_bit
        assign shl_c[gi] = op_a_reg[DATA_WIDTH-gi];
        assign shr_c[gi] = op_a_reg[gi-1];
      end else begin : g_none
        assign shl_c[gi] = 1'b0;
        assign shr_c[gi] = 1'b0;
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Single-cycle ALU
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_c;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (opcode)
      OP_ADD: {alu_c, alu_res} = {1'b0, op_a_reg} + {1'b0, op_b_reg};
      // Borrow falls out as the top bit of the widened difference.
      OP_SUB: {alu_c, alu_res} = {1'b0, op_a_reg} - {1'b0, op_b_reg};
      OP_AND: alu_res = op_a_reg & op_b_reg;
      OP_OR:  alu_res = op_a_reg | op_b_reg;
      OP_XOR: alu_res = op_a_reg ^ op_b_reg;
      OP_SHL: begin
        if (sh_big) begin
          alu_res = '0;
        end else if (op_b_reg != '0) begin
          alu_res = op_a_reg << sh_idx;
          alu_c   = shl_c[sh_idx];
        end else begin
          alu_res = op_a_reg;
        end
      end
      OP_SHR: begin
        if (sh_big) begin
          alu_res = '0;
        end else if (op_b_reg != '0) begin
          alu_res = op_a_reg >> sh_idx;
          alu_c   = shr_c[sh_idx];
        end else begin
          alu_res = op_a_reg;
        end
      end
      OP_MOV: alu_res = op_a_reg;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Optional iterative multiplier (shift-add, one multiplier bit per cycle).
  // prod_reg holds {partial high half, remaining multiplier bits}; after
  // DATA_WIDTH steps it holds the full 2*DATA_WIDTH product.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] exec_res;
  logic                  exec_c;
  logic                  exec_done;

`ifdef MCU_EXU_MUL_EN
  localparam int CNTW = $clog2(DATA_WIDTH) + 1;

  logic [2*DATA_WIDTH-1:0] prod_reg, prod_next;
  logic [DATA_WIDTH:0]     mul_sum;
  logic [CNTW-1:0]         mul_cnt_reg;
  logic                    is_mul;
  logic                    mul_last;

  assign is_mul   = (opcode == OP_MUL);
  assign mul_last = (mul_cnt_reg == CNTW'(DATA_WIDTH-1));

  always_comb begin
    mul_sum   = {1'b0, prod_reg[2*DATA_WIDTH-1:DATA_WIDTH]}
              + (prod_reg[0] ? {1'b0, op_a_reg} : '0);
    prod_next = {mul_sum, prod_reg[DATA_WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_reg    <= '0;
      mul_cnt_reg <= '0;
    end else if (state_reg == S_DECODE) begin
      // Multiplier operand enters alongside op_b capture.
      prod_reg    <= {{DATA_WIDTH{1'b0}}, bus.rf_data_r_2};
      mul_cnt_reg <= '0;
    end else if (state_reg == S_EXEC && is_mul) begin
      prod_reg    <= prod_next;
      mul_cnt_reg <= mul_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    if (is_mul) begin
      exec_res  = prod_next[DATA_WIDTH-1:0];
      exec_c    = |prod_next[2*DATA_WIDTH-1:DATA_WIDTH];
      exec_done = mul_last;
    end else begin
      exec_res  = alu_res;
      exec_c    = alu_c;
      exec_done = 1'b1;
    end
  end
`else
  always_comb begin
    exec_res  = alu_res;
    exec_c    = alu_c;
    exec_done = 1'b1;
  end
`endif

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (bus.instr_valid) state_next = S_DECODE;
      S_DECODE: state_next = S_EXEC;
      S_EXEC:   if (exec_done) state_next = S_WB;
      S_WB:     state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      instr_reg  <= '0;
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      result_reg <= '0;
      carry_reg  <= 1'b0;
      flag_z_reg <= 1'b0;
      flag_c_reg <= 1'b0;
    end else begin
      state_reg <= state_next;

      // instr is only sampled on the handshake edge.
      if (state_reg == S_IDLE && bus.instr_valid)
        instr_reg <= bus.instr;

      if (state_reg == S_DECODE) begin
        op_a_reg <= bus.rf_data_r_1;
        op_b_reg <= bus.rf_data_r_2;
      end

      if (state_reg == S_EXEC && exec_done) begin
        result_reg <= exec_res;
        carry_reg  <= exec_c;
      end

      if (state_reg == S_WB && op_writes) begin
        flag_z_reg <= (result_reg == '0);
        if (op_sets_c)
          flag_c_reg <= carry_reg;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.instr_ready = (state_reg == S_IDLE);
  assign bus.busy        = (state_reg != S_IDLE);
  assign bus.rf_addr_r_1 = rs1;
  assign bus.rf_addr_r_2 = rs2;
  assign bus.rf_we       = (state_reg == S_WB) && op_writes;
  assign bus.rf_addr_w   = rd;
  assign bus.rf_data_w   = result_reg;
  assign bus.illegal_op  = (state_reg == S_WB) && op_illegal;
  assign bus.flag_z      = flag_z_reg;
  assign bus.flag_c      = flag_c_reg;

endmodule

// File: tb/tb_mcu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_mcu_exec_unit
//   Bench for mcu_exec_unit: a behavioural register file around the DUT,
//   a table of directed vectors, a few hand-written multi-cycle sequences
//   (back-to-back dependency, reset during EXEC) and randomized instructions
//   checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_mcu_exec_unit;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int IW = 4 + 3*AW;
  localparam int M  = 1 << DW;
`ifdef MCU_EXU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;

  mcu_exec_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mcu_exec_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment register file: async read, synchronous write.
  logic [DW-1:0] rf_mem [16];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  assign bus.rf_data_r_1 = rf_mem[bus.rf_addr_r_1];
  assign bus.rf_data_r_2 = rf_mem[bus.rf_addr_r_2];

  always @(posedge clk) begin
    if (bus.rf_we)
      rf_mem[bus.rf_addr_w] <= bus.rf_data_w;
    else if (pre_we)
      rf_mem[pre_addr] <= pre_data;
  end

  // Reference state
  int ref_rf [16];
  int ref_z, ref_c;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input int got, input int exp);
    total_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Reference model from the opcode rules, in plain integer arithmetic.
  function automatic void model(input int op, input int a, input int b,
                                output int we, output int ill, output int res,
                                output int c, output int cupd);
    int full;
    we = 0; ill = 0; res = 0; c = 0; cupd = 0;
    case (op)
      0: ;
      1: begin full = a + b; res = full % M; c = (full >= M); we = 1; cupd = 1; end
      2: begin res = (a - b + M) % M; c = (a < b); we = 1; cupd = 1; end
      3: begin res = a & b; we = 1; cupd = 1; end
      4: begin res = a | b; we = 1; cupd = 1; end
      5: begin res = a ^ b; we = 1; cupd = 1; end
      6: begin
        we = 1; cupd = 1;
        if (b == 0) res = a;
        else if (b >= DW) res = 0;
        else begin full = a * (1 << b); res = full % M; c = (full / M) % 2; end
      end
      7: begin
        we = 1; cupd = 1;
        if (b == 0) res = a;
        else if (b >= DW) res = 0;
        else begin res = a / (1 << b); c = (a / (1 << (b - 1))) % 2; end
      end
      8: begin res = a; we = 1; end
      9: begin
        if (MUL_EN) begin
          full = a * b; res = full % M; c = (full >= M); we = 1; cupd = 1;
        end else ill = 1;
      end
      default: ill = 1;
    endcase
  endfunction

  task automatic set_reg(input int a, input int d);
    pre_we   = 1'b1;
    pre_addr = AW'(a);
    pre_data = DW'(d);
    @(negedge clk);
    pre_we   = 1'b0;
    ref_rf[a] = d % M;
  endtask

  // Issue one instruction from a negedge in IDLE, observe it to completion,
  // compare against the model and return the observed write.
  task automatic run_instr(input int op, input int rd, input int rs1,
                           input int rs2, input bit hold,
                           output int g_we, output int g_data);
    int a, b, we, ill, res, c, cupd, lat, cyc, nbusy;
    int we_cnt, we_cyc, ill_cnt, ill_cyc, g_addr;
    logic [3:0] f_op, f_rd, f_rs1, f_rs2;
    a = ref_rf[rs1];
    b = ref_rf[rs2];
    model(op, a, b, we, ill, res, c, cupd);
    lat = (op == 9 && MUL_EN) ? 2 + DW : 3;
    f_op = 4'(op); f_rd = 4'(rd); f_rs1 = 4'(rs1); f_rs2 = 4'(rs2);

    chk("ready_before_issue", int'(bus.instr_ready), 1);
    bus.instr       = {f_op, f_rd, f_rs1, f_rs2};
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1;
    if (hold) bus.instr = IW'($urandom);
    else      bus.instr_valid = 1'b0;

    we_cnt = 0; we_cyc = 0; ill_cnt = 0; ill_cyc = 0; g_addr = 0; g_data = 0;
    nbusy = 40;
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (!bus.busy) begin
        nbusy = cyc - 1;
        break;
      end
      if (bus.rf_we) begin
        we_cnt++; we_cyc = cyc;
        g_addr = int'(bus.rf_addr_w);
        g_data = int'(bus.rf_data_w);
      end
      if (bus.illegal_op) begin
        ill_cnt++; ill_cyc = cyc;
      end
    end
    bus.instr_valid = 1'b0;
    g_we = we_cnt;

    if (we) begin
      ref_rf[rd] = res;
      ref_z = (res == 0);
      if (cupd) ref_c = c;
    end

    $display("txn op=%0d rd=%0d rs1=%0d rs2=%0d a=%0d b=%0d busy_cycles=%0d we=%0d data=%0d ill=%0d z=%0d c=%0d",
             op, rd, rs1, rs2, a, b, nbusy, we_cnt, g_data, ill_cnt,
             bus.flag_z, bus.flag_c);

    chk("latency", nbusy, lat);
    chk("we_count", we_cnt, we);
    chk("illegal_count", ill_cnt, ill);
    if (we) begin
      chk("we_cycle", we_cyc, lat);
      chk("waddr", g_addr, rd);
      chk("wdata", g_data, res);
    end
    if (ill) chk("illegal_cycle", ill_cyc, lat);
    chk("flag_z", int'(bus.flag_z), ref_z);
    chk("flag_c", int'(bus.flag_c), ref_c);
  endtask

  typedef struct {
    int op, rd, rs1, rs2, a, b;
    int we, data, z, c;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g_we, g_data, rst_we_cnt;

    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    pre_we          = 1'b0;
    pre_addr        = '0;
    pre_data        = '0;
    ref_z = 0; ref_c = 0;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_we", int'(bus.rf_we), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", int'(bus.instr_ready), 1);
    chk("rel_busy", int'(bus.busy), 0);
    chk("rel_we", int'(bus.rf_we), 0);
    chk("rel_illegal", int'(bus.illegal_op), 0);
    chk("rel_flag_z", int'(bus.flag_z), 0);
    chk("rel_flag_c", int'(bus.flag_c), 0);

    for (int i = 0; i < 16; i++) set_reg(i, $urandom_range(0, M-1));

    // ---------------- directed table ----------------
    //               op rd rs1 rs2   a     b    we data  z  c
    tbl[0]  = '{ 1,  3, 1,  2, 200,  100,  1,  44, 0, 1};
    tbl[1]  = '{ 8,  5, 8,  0,   0,    0,  1,   0, 1, 1};
    tbl[2]  = '{ 2,  4, 1,  2,   5,    5,  1,   0, 1, 0};
    tbl[3]  = '{ 2,  7, 2,  1,   5,    6,  1, 255, 0, 1};
    tbl[4]  = '{ 0,  9, 1,  2,   7,    9,  0,   0, 0, 1};
    tbl[5]  = '{ 6,  5, 1,  2, 129,    1,  1,   2, 0, 1};
    tbl[6]  = '{ 7,  6, 1,  2, 129,    9,  1,   0, 1, 0};
    tbl[7]  = '{12, 10, 1,  2,  33,   44,  0,   0, 1, 0};
    tbl[8]  = '{ 5, 11, 1,  2, 170,   85,  1, 255, 0, 0};
`ifdef MCU_EXU_MUL_EN
    tbl[9]  = '{ 9, 12, 1,  2,  16,   17,  1,  16, 0, 1};
`else
    tbl[9]  = '{ 9, 12, 1,  2,  16,   17,  0,   0, 0, 0};
`endif
    tbl[10] = '{ 3, 13, 1,  2, 240,   15,  1,   0, 1, 0};
    tbl[11] = '{ 7, 14, 1,  2, 128,    7,  1,   1, 0, 0};
    tbl[12] = '{ 6, 15, 1,  2, 129,    0,  1, 129, 0, 0};

    for (int i = 0; i < 13; i++) begin
      set_reg(tbl[i].rs1, tbl[i].a);
      set_reg(tbl[i].rs2, tbl[i].b);
      run_instr(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, 1'b0, g_we, g_data);
      chk("tbl_we", g_we, tbl[i].we);
      if (tbl[i].we != 0) chk("tbl_data", g_data, tbl[i].data);
      chk("tbl_flag_z", int'(bus.flag_z), tbl[i].z);
      chk("tbl_flag_c", int'(bus.flag_c), tbl[i].c);
    end

    // ---------------- back-to-back dependency ----------------
    // ADD r3 with instr_valid held (and instr scrambled) while busy, then
    // MOV r5 <- r3 issued immediately: r5 must receive the new r3.
    set_reg(1, 30);
    set_reg(2, 50);
    run_instr(1, 3, 1, 2, 1'b1, g_we, g_data);
    chk("b2b_add", g_data, 80);
    run_instr(8, 5, 3, 0, 1'b0, g_we, g_data);
    chk("b2b_mov", g_data, 80);

    // rd == rs1: operand captured before the write
    set_reg(1, 17);
    set_reg(2, 4);
    run_instr(1, 1, 1, 2, 1'b0, g_we, g_data);
    chk("rd_eq_rs1", g_data, 21);

    // ---------------- reset during EXEC of an ADD ----------------
    set_reg(1, 10);
    set_reg(2, 20);
    bus.instr       = {4'd1, 4'd9, 4'd1, 4'd2};
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(negedge clk);                 // DECODE
    @(negedge clk);                 // EXEC
    chk("pre_abort_busy", int'(bus.busy), 1);
    rst_n = 1'b0;
    rst_we_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      #1 if (bus.rf_we) rst_we_cnt++;
      @(negedge clk);
      if (bus.rf_we) rst_we_cnt++;
    end
    chk("abort_no_we", rst_we_cnt, 0);
    chk("abort_busy", int'(bus.busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", int'(bus.instr_ready), 1);
    chk("abort_busy_after", int'(bus.busy), 0);
    chk("abort_r9_untouched", int'(rf_mem[9]), ref_rf[9]);
    chk("abort_flag_z", int'(bus.flag_z), 0);
    chk("abort_flag_c", int'(bus.flag_c), 0);
    ref_z = 0;
    ref_c = 0;

    // ---------------- randomized instructions ----------------
    for (int i = 0; i < 40; i++) begin
      int op, rd, rs1, rs2;
      if ($urandom_range(0, 3) == 0) set_reg($urandom_range(0, 15), $urandom_range(0, M-1));
      op  = (i % 10 == 0) ? 9 : $urandom_range(0, 15);
      rd  = $urandom_range(0, 15);
      rs1 = $urandom_range(0, 15);
      rs2 = $urandom_range(0, 15);
      if ((op == 6 || op == 7) && $urandom_range(0, 1) == 1)
        set_reg(rs2, $urandom_range(0, DW + 2));
      run_instr(op, rd, rs1, rs2, 1'($urandom_range(0, 1)), g_we, g_data);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mcu_exec_unit.md
Name: mcu_exec_unit

Overview:
- Execute/writeback sequencer that sits directly in front of the MCU register file.
- Accepts one decoded instruction word per transaction over a valid/ready handshake. Drives the register file's two asynchronous read ports, latches the operands, computes an ALU result and writes it back through the register file's synchronous write port.
- Also holds the zero/carry status flags for the branch logic.

Parameters:
- ADDR_WIDTH, 4, register index width; matches the register file address width.
- DATA_WIDTH, 8, operand/result width; matches the register file data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction word present.
- instr_ready  out  1  unit can accept an instruction.
- instr  in  4+3*ADDR_WIDTH  {opcode[3:0], rd, rs1, rs2}, with opcode in the MSBs.
- rf_addr_r_1  out  ADDR_WIDTH  read address 1 (= latched rs1).
- rf_addr_r_2  out  ADDR_WIDTH  read address 2 (= latched rs2).
- rf_data_r_1  in  DATA_WIDTH  async read data 1.
- rf_data_r_2  in  DATA_WIDTH  async read data 2.
- rf_we  out  1  register file write enable.
- rf_addr_w  out  ADDR_WIDTH  write address (= latched rd).
- rf_data_w  out  DATA_WIDTH  write data.
- busy  out  1  high whenever state != IDLE.
- illegal_op  out  1  one-cycle pulse for an undefined opcode.
- flag_z  out  1  zero flag.
- flag_c  out  1  carry/borrow flag.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; instruction register, operand registers, result, flags, rf_we, illegal_op all 0.
  - instr_ready=1 once reset is released.
  - Reset asserted mid-operation aborts the instruction; no write occurs.
- States: IDLE, DECODE, EXEC, WB.
  - IDLE: instr_ready=1. If instr_valid=1, latch instr and go to DECODE. Otherwise stay.
  - DECODE: rf_addr_r_1/2 come from the latched rs1/rs2; at the clock edge capture rf_data_r_1/2 into operand A/B. Go to EXEC.
  - EXEC: compute the result. Single-cycle ops go to WB after 1 cycle. MUL stays in EXEC for exactly DATA_WIDTH cycles.
  - WB: rf_we=1 for exactly this cycle with rf_addr_w=rd and rf_data_w=result. Flags update at the end of WB. Go to IDLE.
- Timing:
  - Handshake occurs at edge T → DECODE in T+1, EXEC in T+2, WB in T+3, IDLE (ready) in T+4.
  - Back-to-back throughput is one instruction per 4 cycles; MUL takes 3+DATA_WIDTH cycles.
- Hazards: the write lands before the next DECODE, so no hazard logic is required. An instruction that reads the previous rd sees the new value.
- Opcodes (results truncated to DATA_WIDTH):
  - 0 NOP: no write, flags unchanged.
  - 1 ADD: c = carry-out.
  - 2 SUB (A-B): c = borrow (A<B).
  - 3 AND, 4 OR, 5 XOR: c = 0.
  - 6 SHL A by B: c = last bit shifted out.
  - 7 SHR A by B (logical): c = last bit shifted out.
  - Shifts: B=0 gives result A, c=0. B>=DATA_WIDTH gives result 0, c=0.
  - 8 MOV: result = A, c unchanged.
  - 9 MUL: shift-add, result = low half of A*B, c = OR of high-half bits.
  - 10–15 illegal.
- Zero flag: z = (result==0) for every writing op.
- Illegal opcode: goes through all states, but rf_we stays 0 in WB, illegal_op=1 in the WB cycle, flags unchanged.
- rd=rs1 or rd=rs2 is legal; operands are captured before the write.
- instr_valid held high during busy is ignored until IDLE. instr is sampled only on the handshake edge.

Optional Feature:
- Macro MCU_EXU_MUL_EN.
- Defined: opcode 9 is the iterative multiplier described above.
- Undefined: no multiplier logic is built. Opcode 9 is treated as illegal (illegal_op pulse, no write, 4-cycle latency).

Test Plan:
- Reset release → instr_ready=1, busy=0, rf_we=0, flag_z=0, flag_c=0. Assert rst_n=0 during EXEC of an ADD → no rf_we pulse, state IDLE.
- R1=200, R2=100, ADD rd=3 → rf_we high exactly 3 cycles after the handshake, rf_addr_w=3, rf_data_w=44, c=1, z=0.
- R1=5, R2=5, SUB rd=4 → data 0, z=1, c=0. Then SUB R2−R1 with R1=6, R2=5 → data 255, c=1.
- SHL R1=0x81 by R2=1 → 0x02, c=1. SHR 0x81 by 9 → 0x00, c=0, z=1.
- With MCU_EXU_MUL_EN: MUL 16*17 → 0x10, c=1, latency 11 cycles. Without the macro: opcode 9 → illegal_op pulse, no write.
- Opcode 12 → illegal_op=1 for one cycle, rf_we=0, flags unchanged. Back-to-back ADD r3 then MOV r5←r3 → r5 holds the new r3.
